// File: rtl/mips_dmem_ctrl_if.sv
// Bundle of the core load/store port and the external SRAM port.
//   master : core + SRAM side (drives core requests and SRAM responses)
//   slave  : mips_dmem_ctrl (drives load data, stall/exception, SRAM requests)
interface mips_dmem_ctrl_if;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  // core side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [BW-1:0] mem_write_en;
  logic          mem_read_en;
  logic [DW-1:0] mem_data_out;
  logic          mem_stall;
  logic          mem_excpt;

  // SRAM side
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic          sram_ack;
  logic [DW-1:0] sram_rdata;

  modport master (
    output mem_addr, mem_data_in, mem_write_en, mem_read_en, sram_ack, sram_rdata,
    input  mem_data_out, mem_stall, mem_excpt,
           sram_req, sram_we, sram_addr, sram_wdata, sram_be
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_write_en, mem_read_en, sram_ack, sram_rdata,
    output mem_data_out, mem_stall, mem_excpt,
           sram_req, sram_we, sram_addr, sram_wdata, sram_be
  );
endinterface

// File: rtl/mips_dmem_ctrl.sv
// Data-memory controller between the MIPS core load/store port and a
// variable-latency single-port SRAM. Stores post into a 2-entry write buffer
// that drains in the background; loads stall until the SRAM returns data.
// Loads hitting a buffered address wait for the buffer to empty.
// Ports:
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : core request/response and SRAM request/ack (slave modport)
module mips_dmem_ctrl #(
  parameter logic [29:0] DSEG_LO = 30'h0400_0000,
  parameter logic [29:0] DSEG_HI = 30'h04FF_FFFF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_b,
  mips_dmem_ctrl_if.slave bus
);

  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } wb_entry_t;

  state_e           state_q, state_d;
  wb_entry_t        wb_q [DEPTH];
  wb_entry_t        wb_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             sram_req_q, sram_req_d;
  logic             sram_we_q, sram_we_d;
  logic [AW-1:0]    sram_addr_q, sram_addr_d;
  logic [DW-1:0]    sram_wdata_q, sram_wdata_d;
  logic [BW-1:0]    sram_be_q, sram_be_d;
  logic [DW-1:0]    data_out_q, data_out_d;
  logic             to_excpt_q, to_excpt_d;
  logic             rd_to_q, rd_to_d;

  logic      is_store_c, is_load_c, in_range_c, range_fault_c;
  logic      hit_c, ld_go_c, enq_c, deq_c, timeout_c, mem_stall_c;
  wb_entry_t new_entry_c;

  // Request decode; a nonzero byte mask wins over mem_read_en.
  assign is_store_c    = |bus.mem_write_en;
  assign is_load_c     = bus.mem_read_en & ~is_store_c;
  assign in_range_c    = (bus.mem_addr >= DSEG_LO) && (bus.mem_addr <= DSEG_HI);
  assign range_fault_c = (is_store_c | is_load_c) & ~in_range_c;

  // Load address against every valid buffer entry (including the one draining).
  assign hit_c = ((count_q > CNT_W'(0)) && (wb_q[0].addr == bus.mem_addr)) ||
                 ((count_q > CNT_W'(1)) && (wb_q[1].addr == bus.mem_addr));

  // rd_to_q marks the exception cycle of a read timeout: the core is released, so no reissue.
  assign ld_go_c     = is_load_c & in_range_c & ~hit_c & ~rd_to_q;
  assign enq_c       = is_store_c & in_range_c & (count_q != CNT_W'(DEPTH));
  assign timeout_c   = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign new_entry_c = '{addr: bus.mem_addr, data: bus.mem_data_in, be: bus.mem_write_en};

  // Stall: full buffer on store; on load, stall unless the data (or a timeout) is being delivered.
  always_comb begin
    mem_stall_c = 1'b0;
    if (rst_b && in_range_c) begin
      if (is_store_c) begin
        mem_stall_c = (count_q == CNT_W'(DEPTH));
      end else if (is_load_c) begin
        if (hit_c)                              mem_stall_c = 1'b1;
        else if ((state_q == RD_DONE) || rd_to_q) mem_stall_c = 1'b0;
        else                                    mem_stall_c = 1'b1;
      end
    end
  end

  // Next-state: SRAM sequencing and write-buffer update.
  always_comb begin
    state_d      = state_q;
    wb_d         = wb_q;
    count_d      = count_q;
    to_cnt_d     = to_cnt_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_be_d    = sram_be_q;
    data_out_d   = data_out_q;
    to_excpt_d   = 1'b0;
    rd_to_d      = 1'b0;
    deq_c        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ld_go_c) begin
          state_d     = RD_WAIT;
          sram_req_d  = 1'b1;
          sram_we_d   = 1'b0;
          sram_addr_d = bus.mem_addr;
          sram_be_d   = {BW{1'b1}};
          to_cnt_d    = '0;
        end else if (count_q != CNT_W'(0)) begin
          state_d      = WR_WAIT;
          sram_req_d   = 1'b1;
          sram_we_d    = 1'b1;
          sram_addr_d  = wb_q[0].addr;
          sram_wdata_d = wb_q[0].data;
          sram_be_d    = wb_q[0].be;
          to_cnt_d     = '0;
        end
      end
      RD_WAIT: begin
        if (bus.sram_ack) begin
          state_d    = RD_DONE;
          sram_req_d = 1'b0;
          data_out_d = bus.sram_rdata;
        end else if (timeout_c) begin
          state_d    = IDLE;
          sram_req_d = 1'b0;
          to_excpt_d = 1'b1;
          rd_to_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WR_WAIT: begin
        if (bus.sram_ack) begin
          state_d    = IDLE;
          sram_req_d = 1'b0;
          deq_c      = 1'b1;
        end else if (timeout_c) begin
          // Timed-out write is dropped rather than retried.
          state_d    = IDLE;
          sram_req_d = 1'b0;
          deq_c      = 1'b1;
          to_excpt_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // enq and deq together only happen with one entry: the new entry becomes the head.
    unique case ({enq_c, deq_c})
      2'b10: begin
        wb_d[count_q[0]] = new_entry_c;
        count_d          = count_q + CNT_W'(1);
      end
      2'b01: begin
        wb_d[0] = wb_q[1];
        count_d = count_q - CNT_W'(1);
      end
      2'b11:   wb_d[0] = new_entry_c;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      wb_q         <= '{default: '0};
      count_q      <= '0;
      to_cnt_q     <= '0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_be_q    <= '0;
      data_out_q   <= '0;
      to_excpt_q   <= 1'b0;
      rd_to_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_q         <= wb_d;
      count_q      <= count_d;
      to_cnt_q     <= to_cnt_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_be_q    <= sram_be_d;
      data_out_q   <= data_out_d;
      to_excpt_q   <= to_excpt_d;
      rd_to_q      <= rd_to_d;
    end
  end

  assign bus.mem_data_out = data_out_q;
  assign bus.mem_stall    = mem_stall_c;
  assign bus.mem_excpt    = rst_b & (range_fault_c | to_excpt_q);
  assign bus.sram_req     = sram_req_q;
  assign bus.sram_we      = sram_we_q;
  assign bus.sram_addr    = sram_addr_q;
  assign bus.sram_wdata   = sram_wdata_q;
  assign bus.sram_be      = sram_be_q;

endmodule

// File: doc/mips_dmem_ctrl.md
# mips_dmem_ctrl

Data-memory controller between the single-cycle MIPS core's word-addressed load/store port and an external single-port SRAM with variable latency. Stores post into a 2-entry write buffer and drain in the background. Loads issue as SRAM reads and stall the core until the data returns. A load that hits a buffered address waits for the buffer to drain, so ordering is never violated. Out-of-range accesses and SRAM timeouts raise an exception back to the core.

## Interface
- DSEG_LO, 30'h04000000, lowest valid word address (inclusive)
- DSEG_HI, 30'h04FFFFFF, highest valid word address (inclusive)
- TIMEOUT, 64, maximum cycles sram_req may stay high without sram_ack
- clk  input  1  clock, all state changes on the rising edge
- rst_b  input  1  reset: asynchronous, active-low
- mem_addr  input  30  word address from core
- mem_data_in  input  32  store data from core
- mem_write_en  input  4  byte write mask; nonzero means store
- mem_read_en  input  1  load request; ignored when mem_write_en is nonzero
- mem_data_out  output  32  load data to core, registered
- mem_stall  output  1  core must hold its request and not advance its PC
- mem_excpt  output  1  access faulted (range or timeout)
- sram_req  output  1  SRAM request, held until ack
- sram_we  output  1  1 means write, 0 means read
- sram_addr  output  30  SRAM word address
- sram_wdata  output  32  SRAM write data
- sram_be  output  4  SRAM byte enables
- sram_ack  input  1  SRAM completes the request in this cycle
- sram_rdata  input  32  read data, valid when sram_ack=1 and sram_we=0

## Operation
- Write buffer: 2-entry FIFO of {addr, data, be}. The count ranges from 0 to 2. The head entry drains to the SRAM.
- Range check (combinational): a request is in range when DSEG_LO ≤ mem_addr ≤ DSEG_HI.
- Out-of-range request: mem_excpt=1 in the same cycle, mem_stall=0, nothing is enqueued or issued.
- Store, in range:
  - If count<2: enqueue at the clock edge, mem_stall=0 in that cycle.
  - If count==2: mem_stall=1. A slot freed by an ack in the same cycle does not bypass the stall.
- Load, in range:
  - Address matches any valid buffer entry: mem_stall=1 until the buffer is empty, then the load is treated as a miss.
  - No match: mem_stall=1 and a read is issued.
- Arbitration when the SRAM is idle: a pending no-match load takes priority over a drain.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RD_DONE.
  - IDLE → RD_WAIT: a load miss is pending. Register sram_req=1, sram_we=0, sram_addr=mem_addr.
  - IDLE → WR_WAIT: no load miss and count>0. Present the head entry with sram_we=1.
  - RD_WAIT → RD_DONE on sram_ack. Capture sram_rdata into mem_data_out and deassert sram_req.
  - RD_DONE → IDLE. mem_stall=0 in this cycle and the core consumes mem_data_out.
  - WR_WAIT → IDLE on sram_ack. Dequeue the head and deassert sram_req.
  - RD_WAIT or WR_WAIT → IDLE when the timeout counter reaches TIMEOUT:
    - drop sram_req and pulse mem_excpt for 1 cycle;
    - for a read, mem_stall=0 in that cycle;
    - for a write, the head entry is discarded.
- The timeout counter clears on entering RD_WAIT or WR_WAIT and increments each cycle while waiting.
- While sram_req=1, sram_addr, sram_we, sram_wdata and sram_be are stable.
- sram_be is 4'b1111 for reads.
- When mem_write_en is nonzero and mem_read_en=1, the access is a store.
- Reset, including mid-operation:
  - the buffer empties and pending stores are lost;
  - the FSM returns to IDLE;
  - all outputs are 0: mem_data_out=32'h0, mem_stall=0, mem_excpt=0, sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0, sram_be=0.

## Timing
- Load with an idle SRAM and ack after k cycles (k≥0 after req rises):
  - request at cycle N;
  - sram_req rises at N+1;
  - ack at N+1+k;
  - mem_data_out valid and mem_stall=0 at N+2+k.
  - Minimum latency is 2 stall cycles.
- Store with count<2: zero stall. The drain starts no earlier than the cycle after enqueue.
- A load behind a busy drain waits for the current write ack, then follows the normal load timing. The SRAM is never preempted mid-request.
- mem_excpt for a range fault is combinational. Timeout mem_excpt is registered and lasts 1 cycle.
- mem_stall is combinational from the request inputs and the FSM/buffer state.
- Ack arriving while sram_req=0 is ignored.

## Test plan
- Load with addr 30'h04000010 and sram_ack delayed by 3 cycles (returning 32'hDEADBEEF):
  - mem_stall high for 5 cycles;
  - at cycle N+5, mem_data_out=32'hDEADBEEF and mem_stall=0.
- Back-to-back stores with the SRAM ack held low:
  - the first 2 stores have no stall;
  - the 3rd store stalls until the first ack;
  - the SRAM sees the writes in program order with the correct be.
- Store to 30'h04000020 (data 32'h11223344, be 4'b0011), then load from the same address:
  - the load waits for the buffer to drain before its read issues;
  - the read returns the SRAM contents after the write.
- Load from addr 30'h00000005:
  - mem_excpt=1 and mem_stall=0 in the same cycle;
  - sram_req never rises.
- SRAM never acks a read: sram_req drops after TIMEOUT cycles and mem_excpt pulses once.
- rst_b driven low during WR_WAIT with count=2:
  - sram_req=0 immediately, without waiting for a clock;
  - after release, count=0 and all outputs are 0.
